// File: rtl/hi_pkg.sv
// Shared widths, frame map and channel bundle types for harmonic_interface.
// Readback is controlled by the HI_READBACK_EN macro in the top-level file.
package hi_pkg;

    localparam int NCO_W   = 16;
    localparam int SW_W    = 7;
    localparam int TUNE_W  = 12;
    localparam int FRAME_W = 106;
    localparam int CFG_W   = 104;

    localparam int CH_W    = 44;
    localparam int NCO_OFF = 88;
    localparam int CHA_OFF = 44;
    localparam int CHB_OFF = 0;

    // Bit positions inside one 44-bit channel field
    localparam int SWP_OFF   = 37;
    localparam int SWN_OFF   = 30;
    localparam int CINTN_OFF = 29;
    localparam int ZERON_OFF = 28;
    localparam int FASTN_OFF = 27;
    localparam int TUNEN_OFF = 15;
    localparam int CINTP_OFF = 14;
    localparam int ZEROP_OFF = 13;
    localparam int FASTP_OFF = 12;
    localparam int TUNEP_OFF = 0;

    typedef struct packed {
        logic [SW_W-1:0]   sw;
        logic              cint;
        logic              zero;
        logic              fast;
        logic [TUNE_W-1:0] tune;
    } hi_half_t;

    typedef struct packed {
        hi_half_t p;
        hi_half_t n;
    } hi_chan_t;

    // The p and n halves interleave in the frame, so unpack field by field
    function automatic hi_chan_t decodeChan(input logic [CH_W-1:0] f);
        hi_chan_t c;
        c.p.sw   = f[SWP_OFF +: SW_W];
        c.n.sw   = f[SWN_OFF +: SW_W];
        c.n.cint = f[CINTN_OFF];
        c.n.zero = f[ZERON_OFF];
        c.n.fast = f[FASTN_OFF];
        c.n.tune = f[TUNEN_OFF +: TUNE_W];
        c.p.cint = f[CINTP_OFF];
        c.p.zero = f[ZEROP_OFF];
        c.p.fast = f[FASTP_OFF];
        c.p.tune = f[TUNEP_OFF +: TUNE_W];
        return c;
    endfunction

endpackage

// File: rtl/hi_nco.sv
// Quadrature NCO: free-running phase accumulator with registered I/Q squares.
// Phase is only cleared by reset; increment changes never restart it.
module hi_nco
    import hi_pkg::*;
(
    input  logic             clk,
    input  logic             rstN,
    input  logic [NCO_W-1:0] inc,
    output logic             ncoI,
    output logic             ncoQ
);

    logic [NCO_W-1:0] phase;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            phase <= '0;
            ncoI  <= 1'b0;
            ncoQ  <= 1'b0;
        end else begin
            phase <= phase + inc;
            ncoI  <= phase[NCO_W-1];
            ncoQ  <= phase[NCO_W-1] ^ phase[NCO_W-2];
        end
    end

endmodule

// File: rtl/harmonic_interface.sv
// Serial-configured control block for a two-channel harmonic mixer front end.
// Define HI_READBACK_EN to preload status+cfg into the shift register for readback on dout.
module harmonic_interface
    import hi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              scl_in,
    input  logic              cs_in,
    input  logic              din,
    input  logic              multA,
    input  logic              multB,
    output logic              nco_i,
    output logic              nco_q,
    output logic              clk_out,
    output logic              reset_out,
    output logic              scl_out,
    output logic              cs_out,
    output logic              dout,
    output logic [SW_W-1:0]   swAp,
    output logic [SW_W-1:0]   swAn,
    output logic [SW_W-1:0]   swBp,
    output logic [SW_W-1:0]   swBn,
    output logic              cintAp,
    output logic              cintAn,
    output logic              cintBp,
    output logic              cintBn,
    output logic              zeroAp,
    output logic              zeroAn,
    output logic              zeroBp,
    output logic              zeroBn,
    output logic              fastAp,
    output logic              fastAn,
    output logic              fastBp,
    output logic              fastBn,
    output logic [TUNE_W-1:0] tuneAp,
    output logic [TUNE_W-1:0] tuneAn,
    output logic [TUNE_W-1:0] tuneBp,
    output logic [TUNE_W-1:0] tuneBn
);

    assign clk_out   = clk_in;
    assign reset_out = reset_in;
    assign scl_out   = scl_in;
    assign cs_out    = cs_in;

    // Sync lanes: {multB, multA, din, cs, scl}; cs idles high
    localparam logic [4:0] SYNC_RST = 5'b00010;

    logic [SYNC_STAGES-1:0][4:0] syncQ;
    logic [4:0] syncOut;

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            syncQ <= {SYNC_STAGES{SYNC_RST}};
        end else begin
            syncQ <= {syncQ[SYNC_STAGES-2:0],
                      {multB, multA, din, cs_in, scl_in}};
        end
    end

    assign syncOut = syncQ[SYNC_STAGES-1];

    logic sclS, csS, dinS, multAS, multBS;

    assign sclS   = syncOut[0];
    assign csS    = syncOut[1];
    assign dinS   = syncOut[2];
    assign multAS = syncOut[3];
    assign multBS = syncOut[4];

    logic sclD, csD;

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            sclD <= 1'b0;
            csD  <= 1'b1;
        end else begin
            sclD <= sclS;
            csD  <= csS;
        end
    end

    logic sclRise, csFall, csRise;

    assign sclRise = sclS & ~sclD;
    assign csFall  = ~csS & csD;
    assign csRise  = csS & ~csD;

    logic [FRAME_W-1:0] sr;
    logic [6:0]         bitCnt;
    logic [CFG_W-1:0]   cfg;

    // A cs rise implies csS high, so a coincident scl rise never shifts
    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            sr     <= '0;
            bitCnt <= '0;
            cfg    <= '0;
        end else if (csFall) begin
            bitCnt <= '0;
`ifdef HI_READBACK_EN
            sr     <= {multAS, multBS, cfg};
`endif
        end else if (csRise) begin
            if (bitCnt == 7'(FRAME_W)) begin
                cfg <= sr[CFG_W-1:0];
            end
        end else if (!csS && sclRise) begin
            sr <= {sr[FRAME_W-2:0], dinS};
            if (bitCnt != 7'h7f) begin
                bitCnt <= bitCnt + 7'd1;
            end
        end
    end

`ifndef HI_READBACK_EN
    logic unusedMult;
    assign unusedMult = multAS ^ multBS;
`endif

    assign dout = sr[FRAME_W-1];

    logic [NCO_W-1:0] ncoInc;
    hi_chan_t         chA;
    hi_chan_t         chB;

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            ncoInc <= '0;
            chA    <= '0;
            chB    <= '0;
        end else begin
            ncoInc <= cfg[NCO_OFF +: NCO_W];
            chA    <= decodeChan(cfg[CHA_OFF +: CH_W]);
            chB    <= decodeChan(cfg[CHB_OFF +: CH_W]);
        end
    end

    assign swAp   = chA.p.sw;
    assign swAn   = chA.n.sw;
    assign cintAp = chA.p.cint;
    assign cintAn = chA.n.cint;
    assign zeroAp = chA.p.zero;
    assign zeroAn = chA.n.zero;
    assign fastAp = chA.p.fast;
    assign fastAn = chA.n.fast;
    assign tuneAp = chA.p.tune;
    assign tuneAn = chA.n.tune;

    assign swBp   = chB.p.sw;
    assign swBn   = chB.n.sw;
    assign cintBp = chB.p.cint;
    assign cintBn = chB.n.cint;
    assign zeroBp = chB.p.zero;
    assign zeroBn = chB.n.zero;
    assign fastBp = chB.p.fast;
    assign fastBn = chB.n.fast;
    assign tuneBp = chB.p.tune;
    assign tuneBn = chB.n.tune;

    hi_nco uNco (
        .clk  (clk_in),
        .rstN (reset_in),
        .inc  (ncoInc),
        .ncoI (nco_i),
        .ncoQ (nco_q)
    );

endmodule

// File: tb/tb_harmonic_interface.sv
// Directed + randomized frame bench for harmonic_interface against a frame-level model.
module tb_harmonic_interface;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    logic scl = 1'b0;
    logic cs = 1'b1;
    logic din = 1'b0;
    logic multA = 1'b0;
    logic multB = 1'b0;

    logic nco_i, nco_q, clk_out, reset_out, scl_out, cs_out, dout;
    logic [6:0] swAp, swAn, swBp, swBn;
    logic cintAp, cintAn, cintBp, cintBn;
    logic zeroAp, zeroAn, zeroBp, zeroBn;
    logic fastAp, fastAn, fastBp, fastBn;
    logic [11:0] tuneAp, tuneAn, tuneBp, tuneBn;

    harmonic_interface dut (
        .clk_in(clk), .reset_in(rstN), .scl_in(scl), .cs_in(cs),
        .din(din), .multA(multA), .multB(multB),
        .nco_i(nco_i), .nco_q(nco_q), .clk_out(clk_out),
        .reset_out(reset_out), .scl_out(scl_out), .cs_out(cs_out),
        .dout(dout),
        .swAp(swAp), .swAn(swAn), .swBp(swBp), .swBn(swBn),
        .cintAp(cintAp), .cintAn(cintAn),
        .cintBp(cintBp), .cintBn(cintBn),
        .zeroAp(zeroAp), .zeroAn(zeroAn),
        .zeroBp(zeroBp), .zeroBn(zeroBn),
        .fastAp(fastAp), .fastAn(fastAn),
        .fastBp(fastBp), .fastBn(fastBn),
        .tuneAp(tuneAp), .tuneAn(tuneAn),
        .tuneBp(tuneBp), .tuneBn(tuneBn)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: committed configuration and the 106-bit serial register
    logic [103:0] mCfg = '0;
    logic [105:0] mSr = '0;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    task automatic chkChan(input string tag, input int o,
                           input logic [6:0] sp, input logic [6:0] sn,
                           input logic cp, input logic cn,
                           input logic zp, input logic zn,
                           input logic fp, input logic fn,
                           input logic [11:0] tp, input logic [11:0] tn);
        chk({tag, ".swp"}, 16'(sp), 16'(mCfg[o+43 -: 7]));
        chk({tag, ".swn"}, 16'(sn), 16'(mCfg[o+36 -: 7]));
        chk({tag, ".cintn"}, 16'(cn), 16'(mCfg[o+29]));
        chk({tag, ".zeron"}, 16'(zn), 16'(mCfg[o+28]));
        chk({tag, ".fastn"}, 16'(fn), 16'(mCfg[o+27]));
        chk({tag, ".tunen"}, 16'(tn), 16'(mCfg[o+26 -: 12]));
        chk({tag, ".cintp"}, 16'(cp), 16'(mCfg[o+14]));
        chk({tag, ".zerop"}, 16'(zp), 16'(mCfg[o+13]));
        chk({tag, ".fastp"}, 16'(fp), 16'(mCfg[o+12]));
        chk({tag, ".tunep"}, 16'(tp), 16'(mCfg[o+11 -: 12]));
    endtask

    task automatic checkCfg(input string tag);
        chkChan({tag, ".A"}, 44, swAp, swAn, cintAp, cintAn,
                zeroAp, zeroAn, fastAp, fastAn, tuneAp, tuneAn);
        chkChan({tag, ".B"}, 0, swBp, swBn, cintBp, cintBn,
                zeroBp, zeroBn, fastBp, fastBn, tuneBp, tuneBn);
    endtask

    task automatic sendBit(input logic b);
        din = b;
        scl = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("dout", 16'(dout), 16'(mSr[105]));
        scl = 1'b1;
        mSr = {mSr[104:0], b};
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic startFrame(input logic a, input logic b);
        multA = a;
        multB = b;
        repeat (4) @(posedge clk);
        #1;
        cs = 1'b0;
`ifdef HI_READBACK_EN
        mSr = {a, b, mCfg};
`endif
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic sendFrame(input logic [127:0] bits, input int n,
                             input logic a, input logic b);
        startFrame(a, b);
        for (int i = n - 1; i >= 0; i--) sendBit(bits[i]);
        scl = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        cs = 1'b1;
        if (n == 106) mCfg = bits[103:0];
        repeat (6) @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [103:0] c;
    logic [127:0] r;
    logic [1:0] pat [4];
    logic [1:0] iq;
    logic prev;
    int idx;
    int n;

    initial begin
        pat = '{2'b00, 2'b01, 2'b11, 2'b10};

        // Reset state and combinational pass-throughs
        repeat (4) @(posedge clk);
        #1;
        checkCfg("rst");
        chk("rst.nco_i", 16'(nco_i), 16'h0);
        chk("rst.nco_q", 16'(nco_q), 16'h0);
        chk("rst.dout", 16'(dout), 16'h0);
        chk("rst.reset_out", 16'(reset_out), 16'(rstN));
        chk("rst.clk_out", 16'(clk_out), 16'(clk));
        scl = 1'b1;
        cs = 1'b0;
        #1;
        chk("pt.scl", 16'(scl_out), 16'h1);
        chk("pt.cs", 16'(cs_out), 16'h0);
        scl = 1'b0;
        cs = 1'b1;
        #1;
        chk("pt.scl0", 16'(scl_out), 16'h0);
        chk("pt.cs1", 16'(cs_out), 16'h1);
        @(negedge clk);
        chk("pt.clk0", 16'(clk_out), 16'(clk));
        rstN = 1'b1;
        #1;
        chk("pt.reset1", 16'(reset_out), 16'h1);
        repeat (2) @(posedge clk);
        #1;

        // Directed frame
        c = '0;
        c[103:88] = 16'h4000;
        c[87:81] = 7'h55;
        c[70:59] = 12'hABC;
        c[43:0] = '1;
        sendFrame({24'h0, c}, 106, 1'b1, 1'b0);
        chk("dir.swAp", 16'(swAp), 16'h0055);
        chk("dir.tuneAn", 16'(tuneAn), 16'h0ABC);
        chk("dir.swBn", 16'(swBn), 16'h007f);
        chk("dir.tuneBp", 16'(tuneBp), 16'h0fff);
        checkCfg("dir");

        // I/Q rotation at a quarter-turn per clock
        iq = {nco_i, nco_q};
        idx = 0;
        for (int k = 0; k < 4; k++) if (pat[k] == iq) idx = k;
        for (int k = 1; k < 9; k++) begin
            @(posedge clk);
            #1;
            chk("nco.iq", 16'({nco_i, nco_q}), 16'(pat[(idx + k) % 4]));
        end

        // Random frames; each dout stream is checked against the model
        for (int f = 0; f < 3; f++) begin
            r = rnd128();
            sendFrame(r, 106, 1'($urandom), 1'($urandom));
            checkCfg("rnd");
        end

        // Wrong lengths must not commit
        sendFrame(rnd128(), 105, 1'b0, 1'b1);
        checkCfg("short");
        sendFrame(rnd128(), 107, 1'b1, 1'b1);
        checkCfg("long");

        // Readback of the previous frame with multA=1, multB=0
        r = rnd128();
        sendFrame(r, 106, 1'b1, 1'b0);
        checkCfg("rb1");
        sendFrame(rnd128(), 106, 1'b1, 1'b0);
        checkCfg("rb2");

        // Reset in the middle of a frame
        r = rnd128();
        startFrame(1'b0, 1'b1);
        for (int i = 105; i > 55; i--) sendBit(r[i]);
        rstN = 1'b0;
        scl = 1'b0;
        cs = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        mSr = '0;
        mCfg = '0;
        rstN = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkCfg("midrst");
        sendFrame(rnd128(), 106, 1'b1, 1'b1);
        checkCfg("postrst");

        // Increment of one: nco_i half-period of 32768 clocks
        r = rnd128();
        r[103:88] = 16'h0001;
        sendFrame(r, 106, 1'b0, 1'b0);
        checkCfg("inc1");
        prev = nco_i;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (nco_i === prev && n < 33000);
        chk("inc1.first", 16'(n < 33000), 16'h1);
        prev = nco_i;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (nco_i === prev && n < 33000);
        chk("inc1.period", 16'(n), 16'h8000);

        // Zero increment freezes the outputs
        r = rnd128();
        r[103:88] = 16'h0000;
        sendFrame(r, 106, 1'b0, 1'b0);
        checkCfg("inc0");
        iq = {nco_i, nco_q};
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (k % 8 == 7) chk("inc0.iq", 16'({nco_i, nco_q}), 16'(iq));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
